// File: rtl/enc_input_scheduler_pkg.sv
// Shared encoder constants and the input scheduler state type.
package enc_input_scheduler_pkg;

  localparam int ENC_SYM_NUM = 8;
  localparam int RS_MES_LEN  = 223;
  localparam int RS_COD_LEN  = 255;
  localparam int SCH_PRE_THR = 16;

  typedef enum logic [1:0] {
    SCH_IDL = 2'd0,
    SCH_RUN = 2'd1,
    SCH_DRN = 2'd2,
    SCH_ERR = 2'd3
  } SCH_STATE;

endpackage

// File: rtl/enc_input_scheduler_modcnt.sv
// Modulo-MES_LEN symbol accumulator; exposes the next value and a wrap pulse
// so the caller can act on a codeword boundary in the same cycle.
module enc_sym_modcnt #(
  parameter  int MES_LEN = 223,
  parameter  int ADD_W   = 4,
  localparam int CNT_W   = $clog2(MES_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [ADD_W-1:0] add,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W:0]   sum_s;

  // Sum with single-step modulo reduction; add is always below MES_LEN.
  always_comb begin
    sum_s = {1'b0, cnt_q} + (CNT_W+1)'(add);
    if (sum_s >= (CNT_W+1)'(MES_LEN)) begin
      wrap    = 1'b1;
      cnt_nxt = CNT_W'(sum_s - (CNT_W+1)'(MES_LEN));
    end else begin
      wrap    = 1'b0;
      cnt_nxt = sum_s[CNT_W-1:0];
    end
    if (clr) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_nxt;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/enc_input_scheduler.sv
// Input-side scheduler for the RS encoder: staging buffer pointers/occupancy,
// encoder run gating, codeword counting and sticky stream error flags.
module enc_input_scheduler
  import enc_input_scheduler_pkg::*;
#(
  parameter  int SYM_NUM = ENC_SYM_NUM,
  parameter  int MES_LEN = RS_MES_LEN,
  parameter  int BUF_DEP = 32,
  parameter  int PRE_THR = SCH_PRE_THR,
  localparam int NW      = $clog2(SYM_NUM + 1),
  localparam int PW      = $clog2(BUF_DEP),
  localparam int OW      = $clog2(BUF_DEP + 1),
  localparam int MW      = $clog2(MES_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] in_num,
  input  logic          in_last,
  input  logic [NW-1:0] sel_request,
  input  logic          cw_done,
  output logic          enc_run,
  output logic [PW-1:0] wr_ptr,
  output logic [PW-1:0] rd_ptr,
  output logic [OW-1:0] occupancy,
  output logic [15:0]   cw_count,
  output SCH_STATE      sch_state,
  output logic          err_underflow,
  output logic          err_frame
);

  SCH_STATE      state_q, state_d;
  logic          enc_run_q, enc_run_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [15:0]   cw_count_q, cw_count_d;
  logic          err_uf_q, err_uf_d;
  logic          err_fr_q, err_fr_d;
  logic          last_seen_q, last_seen_d;

  logic          in_ready_s;
  logic          accept_s;
  logic [NW-1:0] push_s;
  logic [NW-1:0] pop_s;
  logic          req_gt_s;
  logic          underflow_s;
  logic          frame_err_s;
  logic          clear_s;
  logic [OW:0]   occ_sum_s;
  logic [MW-1:0] push_mod_s, push_mod_nxt_s, pop_mod_s, pop_mod_nxt_s;
  logic          push_wrap_s, pop_wrap_s;

  // Readiness looks only at registered state so there is no in_valid path.
  always_comb begin
    if (((state_q == SCH_IDL) || (state_q == SCH_RUN)) && !last_seen_q &&
        (occ_q <= OW'(BUF_DEP - SYM_NUM))) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = 1'b0;
    end
  end

  assign accept_s = in_valid & in_ready_s;
  assign clear_s  = (state_q == SCH_DRN) & cw_done;

  // Push/pop amounts; an underflowing request in RUN pops nothing.
  always_comb begin
    push_s      = accept_s ? in_num : '0;
    req_gt_s    = (OW'(sel_request) > occ_q);
    underflow_s = (state_q == SCH_RUN) & req_gt_s;
    if ((state_q != SCH_RUN) && (state_q != SCH_DRN)) begin
      pop_s = '0;
    end else if (underflow_s) begin
      pop_s = '0;
    end else if (req_gt_s) begin
      pop_s = NW'(occ_q);
    end else begin
      pop_s = sel_request;
    end
    occ_sum_s = {1'b0, occ_q} + (OW+1)'(push_s) - (OW+1)'(pop_s);
  end

  enc_sym_modcnt #(.MES_LEN(MES_LEN), .ADD_W(NW)) u_push_mod (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clear_s),
    .add     (push_s),
    .cnt     (push_mod_s),
    .cnt_nxt (push_mod_nxt_s),
    .wrap    (push_wrap_s)
  );

  enc_sym_modcnt #(.MES_LEN(MES_LEN), .ADD_W(NW)) u_pop_mod (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clear_s),
    .add     (pop_s),
    .cnt     (pop_mod_s),
    .cnt_nxt (pop_mod_nxt_s),
    .wrap    (pop_wrap_s)
  );

  // A last beat must close a whole message; other beats must be full.
  always_comb begin
    if (accept_s && ((in_num == '0) ||
                     (!in_last && (in_num != NW'(SYM_NUM))) ||
                     (in_last && (push_mod_nxt_s != '0)))) begin
      frame_err_s = 1'b1;
    end else begin
      frame_err_s = 1'b0;
    end
  end

  // Next-state and bookkeeping; frame error outranks underflow.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q + PW'(push_s);
    rd_ptr_d    = rd_ptr_q + PW'(pop_s);
    occ_d       = occ_sum_s[OW-1:0];
    last_seen_d = last_seen_q | (accept_s & in_last);
    err_fr_d    = err_fr_q | frame_err_s;
    err_uf_d    = err_uf_q | (underflow_s & ~frame_err_s);
    cw_count_d  = pop_wrap_s ? (cw_count_q + 16'd1) : cw_count_q;
    case (state_q)
      SCH_IDL: begin
        if (frame_err_s) begin
          state_d = SCH_ERR;
        end else if ((occ_q >= OW'(PRE_THR)) || (last_seen_q && (occ_q != '0))) begin
          state_d = SCH_RUN;
        end else begin
          state_d = SCH_IDL;
        end
      end
      SCH_RUN: begin
        if (frame_err_s || underflow_s) begin
          state_d = SCH_ERR;
        end else if (last_seen_q && (occ_d == '0)) begin
          state_d = SCH_DRN;
        end else begin
          state_d = SCH_RUN;
        end
      end
      SCH_DRN: begin
        if (cw_done) begin
          state_d     = SCH_IDL;
          wr_ptr_d    = '0;
          rd_ptr_d    = '0;
          last_seen_d = 1'b0;
        end else begin
          state_d = SCH_DRN;
        end
      end
      SCH_ERR: begin
        state_d = SCH_ERR;
      end
      default: begin
        state_d = SCH_ERR;
      end
    endcase
    enc_run_d = (state_d == SCH_RUN) || (state_d == SCH_DRN);
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SCH_IDL;
      enc_run_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      cw_count_q  <= 16'd0;
      err_uf_q    <= 1'b0;
      err_fr_q    <= 1'b0;
      last_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_run_q   <= enc_run_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      cw_count_q  <= cw_count_d;
      err_uf_q    <= err_uf_d;
      err_fr_q    <= err_fr_d;
      last_seen_q <= last_seen_d;
    end
  end

  assign in_ready      = in_ready_s;
  assign enc_run       = enc_run_q;
  assign wr_ptr        = wr_ptr_q;
  assign rd_ptr        = rd_ptr_q;
  assign occupancy     = occ_q;
  assign cw_count      = cw_count_q;
  assign sch_state     = state_q;
  assign err_underflow = err_uf_q;
  assign err_frame     = err_fr_q;

  // Modulo counter values are observed only through their next/wrap outputs.
  logic unused_s;
  assign unused_s = ^{push_mod_s, pop_mod_s, pop_mod_nxt_s, push_wrap_s};

endmodule

// File: tb/tb_enc_input_scheduler.sv
// Directed bench for enc_input_scheduler with default parameters.
module tb_enc_input_scheduler;
  import enc_input_scheduler_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_num;
  logic        in_last;
  logic [3:0]  sel_request;
  logic        cw_done;
  logic        enc_run;
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr;
  logic [5:0]  occupancy;
  logic [15:0] cw_count;
  SCH_STATE    sch_state;
  logic        err_underflow;
  logic        err_frame;

  int total = 0;
  int bad   = 0;
  bit done;

  enc_input_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_num        (in_num),
    .in_last       (in_last),
    .sel_request   (sel_request),
    .cw_done       (cw_done),
    .enc_run       (enc_run),
    .wr_ptr        (wr_ptr),
    .rd_ptr        (rd_ptr),
    .occupancy     (occupancy),
    .cw_count      (cw_count),
    .sch_state     (sch_state),
    .err_underflow (err_underflow),
    .err_frame     (err_frame)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid    = 1'b0;
    in_num      = 4'd0;
    in_last     = 1'b0;
    sel_request = 4'd0;
    cw_done     = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic check_reset(input string tag);
    chk_eq({tag, "_state"}, 32'(sch_state), 32'(SCH_IDL));
    chk_eq({tag, "_run"}, 32'(enc_run), 32'd0);
    chk_eq({tag, "_wr"}, 32'(wr_ptr), 32'd0);
    chk_eq({tag, "_rd"}, 32'(rd_ptr), 32'd0);
    chk_eq({tag, "_occ"}, 32'(occupancy), 32'd0);
    chk_eq({tag, "_cw"}, 32'(cw_count), 32'd0);
    chk_eq({tag, "_euf"}, 32'(err_underflow), 32'd0);
    chk_eq({tag, "_efr"}, 32'(err_frame), 32'd0);
    chk_eq({tag, "_rdy"}, 32'(in_ready), 32'd1);
  endtask

  // Two full beats then one idle cycle: ends in RUN with occupancy 16.
  task automatic preload();
    in_valid = 1'b1;
    in_num   = 4'd8;
    in_last  = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    tick();
  endtask

  // 27 full beats plus a last beat; encoder model pops up to the message end.
  task automatic run_stream(input int last_num, output bit fin);
    int popped = 0;
    int sent   = 0;
    int s;
    fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      in_valid = (sent < 28);
      in_num   = (sent == 27) ? 4'(last_num) : 4'd8;
      in_last  = (sent == 27);
      if (sch_state == SCH_RUN) s = ((223 - popped) >= 8) ? 8 : (223 - popped);
      else s = 0;
      sel_request = 4'(s);
      if (in_valid && in_ready) sent++;
      popped += s;
      tick();
      if ((sch_state == SCH_DRN) || (sch_state == SCH_ERR)) fin = 1'b1;
    end
    idle_inputs();
  endtask

  initial begin
    rst_n = 1'b1;
    idle_inputs();
    do_reset();
    check_reset("rst0");

    // Preload and start latency.
    in_valid = 1'b1; in_num = 4'd8; in_last = 1'b0;
    tick();
    chk_eq("pre_occ8", 32'(occupancy), 32'd8);
    chk_eq("pre_wr8", 32'(wr_ptr), 32'd8);
    tick();
    chk_eq("pre_occ16", 32'(occupancy), 32'd16);
    chk_eq("pre_state_idle", 32'(sch_state), 32'(SCH_IDL));
    chk_eq("pre_run0", 32'(enc_run), 32'd0);
    in_valid = 1'b0;
    tick();
    chk_eq("pre_run1", 32'(enc_run), 32'd1);
    chk_eq("pre_state_run", 32'(sch_state), 32'(SCH_RUN));
    chk_eq("pre_rdy", 32'(in_ready), 32'd1);

    // Back-pressure at a full buffer, then release by a pop.
    in_valid = 1'b1; in_num = 4'd8; sel_request = 4'd0;
    tick();
    chk_eq("bp_occ24", 32'(occupancy), 32'd24);
    chk_eq("bp_rdy24", 32'(in_ready), 32'd1);
    tick();
    chk_eq("bp_occ32", 32'(occupancy), 32'd32);
    chk_eq("bp_rdy32", 32'(in_ready), 32'd0);
    chk_eq("bp_wr_wrap", 32'(wr_ptr), 32'd0);
    sel_request = 4'd8;
    tick();
    chk_eq("bp_occ_back24", 32'(occupancy), 32'd24);
    chk_eq("bp_rd8", 32'(rd_ptr), 32'd8);
    chk_eq("bp_wr_hold", 32'(wr_ptr), 32'd0);
    chk_eq("bp_rdy_again", 32'(in_ready), 32'd1);
    idle_inputs();

    // Full 223-symbol message.
    do_reset();
    run_stream(7, done);
    chk_eq("msg_reached_end", 32'(done), 32'd1);
    chk_eq("msg_state_drn", 32'(sch_state), 32'(SCH_DRN));
    chk_eq("msg_cw1", 32'(cw_count), 32'd1);
    chk_eq("msg_occ0", 32'(occupancy), 32'd0);
    chk_eq("msg_wr31", 32'(wr_ptr), 32'd31);
    chk_eq("msg_rd31", 32'(rd_ptr), 32'd31);
    chk_eq("msg_run_drn", 32'(enc_run), 32'd1);
    chk_eq("msg_rdy_drn", 32'(in_ready), 32'd0);
    cw_done = 1'b1;
    tick();
    cw_done = 1'b0;
    chk_eq("msg_state_idle", 32'(sch_state), 32'(SCH_IDL));
    chk_eq("msg_run0", 32'(enc_run), 32'd0);
    chk_eq("msg_wr0", 32'(wr_ptr), 32'd0);
    chk_eq("msg_rd0", 32'(rd_ptr), 32'd0);
    chk_eq("msg_cw_hold", 32'(cw_count), 32'd1);
    chk_eq("msg_rdy_idle", 32'(in_ready), 32'd1);

    // 224-symbol stream is a frame error.
    do_reset();
    run_stream(8, done);
    chk_eq("fr_reached_end", 32'(done), 32'd1);
    chk_eq("fr_state_err", 32'(sch_state), 32'(SCH_ERR));
    chk_eq("fr_flag", 32'(err_frame), 32'd1);
    chk_eq("fr_no_uf", 32'(err_underflow), 32'd0);
    chk_eq("fr_run0", 32'(enc_run), 32'd0);
    in_valid = 1'b1; in_num = 4'd8;
    tick();
    tick();
    chk_eq("fr_rdy0", 32'(in_ready), 32'd0);
    chk_eq("fr_state_stays", 32'(sch_state), 32'(SCH_ERR));
    do_reset();
    check_reset("rst_err");

    // Underflow in RUN.
    do_reset();
    preload();
    sel_request = 4'd8;
    tick();
    sel_request = 4'd4;
    tick();
    chk_eq("uf_occ4", 32'(occupancy), 32'd4);
    chk_eq("uf_rd12", 32'(rd_ptr), 32'd12);
    sel_request = 4'd8;
    tick();
    chk_eq("uf_flag", 32'(err_underflow), 32'd1);
    chk_eq("uf_state_err", 32'(sch_state), 32'(SCH_ERR));
    chk_eq("uf_run0", 32'(enc_run), 32'd0);
    chk_eq("uf_rd_hold", 32'(rd_ptr), 32'd12);
    chk_eq("uf_occ_hold", 32'(occupancy), 32'd4);
    chk_eq("uf_no_fr", 32'(err_frame), 32'd0);

    // Reset mid-RUN with live inputs.
    do_reset();
    preload();
    sel_request = 4'd8;
    tick();
    chk_eq("mr_rd8", 32'(rd_ptr), 32'd8);
    in_valid = 1'b1; in_num = 4'd8;
    rst_n = 1'b0;
    tick();
    idle_inputs();
    check_reset("rst_mid");
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/enc_input_scheduler.md
# enc_input_scheduler

Input-side scheduler for the RS encoder. It accepts a beat-based symbol stream from upstream (valid/ready, up to `SYM_NUM` symbols per beat) and tracks occupancy of the input staging buffer. It gates the encoder with `enc_run` so the encoder starts only when enough data is staged and stops cleanly after the last codeword. It consumes the encoder controller's per-cycle `sel_request` and produces buffer read/write pointers, codeword bookkeeping and sticky error flags.

## Interface
- `SYM_NUM`, default `ENC_SYM_NUM` (8): symbols per beat and per encoder cycle.
- `MES_LEN`, default `RS_MES_LEN` (223): message symbols per codeword.
- `BUF_DEP`, default 32: staging buffer depth in symbols; power of two, ≥ 2·`SYM_NUM`.
- `PRE_THR`, default 16: occupancy needed to leave IDLE; `SYM_NUM` ≤ `PRE_THR` ≤ `BUF_DEP`.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `in_valid` in 1: upstream beat valid.
- `in_ready` out 1: scheduler accepts the beat.
- `in_num` in clog2(`SYM_NUM`+1): symbols in the beat; must equal `SYM_NUM` unless `in_last`.
- `in_last` in 1: final beat of the stream.
- `sel_request` in clog2(`SYM_NUM`+1): symbols the encoder pops this cycle.
- `cw_done` in 1: one-cycle pulse on the last parity beat of a codeword.
- `enc_run` out 1: encoder enable; the encoder's reset is `rst_n & enc_run`.
- `wr_ptr` out clog2(`BUF_DEP`): next write symbol index.
- `rd_ptr` out clog2(`BUF_DEP`): next read symbol index.
- `occupancy` out clog2(`BUF_DEP`+1): staged symbols.
- `cw_count` out 16: completed messages popped, wraps at 2^16.
- `sch_state` out `SCH_STATE`: current FSM state.
- `err_underflow` out 1: sticky; set on an illegal pop.
- `err_frame` out 1: sticky; set on an illegal stream length or `in_num`.

## Operation
- **States.** FSM states are IDLE, RUN, DRAIN and ERR.
- **Reset.** Reset values: state IDLE, `enc_run` 0, pointers 0, `occupancy` 0, `cw_count` 0, both error flags 0, and internal `push_mod`, `pop_mod` and `last_seen` all 0.
- **Accepting beats.**
  - `in_ready` = (state ∈ {IDLE, RUN}) && !`last_seen` && (`occupancy` ≤ `BUF_DEP` − `SYM_NUM`).
  - A beat is accepted when `in_valid` && `in_ready`.
- **Push (accepted beat).**
  - `wr_ptr` advances by `in_num` (mod `BUF_DEP`).
  - `push_mod` = (`push_mod` + `in_num`) mod `MES_LEN`.
  - If `in_last`, `last_seen` is set.
- **Pop (RUN and DRAIN only).**
  - pop = min(`sel_request`, `occupancy`).
  - `rd_ptr` advances by pop (mod `BUF_DEP`).
  - `pop_mod` = (`pop_mod` + pop) mod `MES_LEN`; each wrap to 0 increments `cw_count`.
- **Occupancy and wrap.**
  - Next value: `occupancy` + push − pop, computed one bit wider; it never exceeds `BUF_DEP`.
  - Pointer wrap is a plain power-of-two truncation.
- **Transitions.**
  - IDLE→RUN: when `occupancy` ≥ `PRE_THR`, or when `last_seen` && `occupancy` > 0.
  - RUN→ERR: when `sel_request` > `occupancy` (the same-cycle push does not count); sets `err_underflow`.
  - RUN→DRAIN: when `last_seen` and the next `occupancy` is 0.
  - DRAIN→IDLE: on `cw_done`.
  - On entering IDLE from DRAIN: pointers, `push_mod`, `pop_mod` and `last_seen` clear; `cw_count` holds.
- **DRAIN behaviour.** A `sel_request` that exceeds `occupancy` is ignored, not an error (tail of the stream); `in_ready` is 0.
- **Frame checks.** On any accepted beat, `err_frame` is set and the state goes to ERR if:
  - `in_num` == 0, or
  - !`in_last` && `in_num` ≠ `SYM_NUM`, or
  - `in_last` && the updated `push_mod` ≠ 0.
- **ERR.** `enc_run` 0, `in_ready` 0, pops ignored; exit only by `rst_n`.
- **Precedence.** Within one cycle: a frame error beats an underflow, which beats a normal transition. `cw_done` outside DRAIN is ignored.

## Timing
- All outputs are registered except `in_ready`, which is combinational from registered state and `occupancy` only (no path from `in_valid`).
- **Push latency.** A push at edge k is visible in `occupancy` and `wr_ptr` after edge k.
- **Start latency.** The threshold is reached after edge t; `enc_run` = 1 after edge t+1.
- **Stop latency.** `cw_done` sampled at edge u gives `enc_run` = 0 after edge u.
- **Simultaneous events.** A push and a pop in the same cycle both apply; a full buffer with a pop of `SYM_NUM` still shows `in_ready` 0 that cycle, because readiness uses the current occupancy.
- **Reset mid-operation.** Reset overrides everything on the next edge, including ERR.

## Structure
- Shared encoder package holds:
  - `typedef enum logic [1:0] {SCH_IDL, SCH_RUN, SCH_DRN, SCH_ERR} SCH_STATE`
  - the default `PRE_THR` constant
  - existing `ENC_SYM_NUM`, `RS_MES_LEN`, `RS_COD_LEN`.
- One sub-module: `enc_sym_modcnt`, a modulo-`MES_LEN` accumulator with a wrap pulse. It is instantiated twice, for `push_mod` and `pop_mod`.

## Test plan
All scenarios use default parameters.
1. **Preload.** Two full beats from IDLE → `occupancy` 16, then `enc_run` 1 one cycle later; `in_ready` remains 1.
2. **Back-pressure.** Beats every cycle with `sel_request` 0 in RUN → `occupancy` reaches 32, `in_ready` 0 at 32 and 1 again when `occupancy` is 24.
3. **Full message.** 27 beats of 8 plus a last beat with `in_num` 7 (223 symbols), encoder popping 8 per cycle → `cw_count` 1, state DRAIN, then `cw_done` → IDLE, `enc_run` 0, pointers 0.
4. **Frame error.** Last beat with `in_num` 8 after 27 full beats (224 symbols) → `err_frame` 1, state ERR, `in_ready` 0 until reset.
5. **Underflow.** In RUN with `occupancy` 4, `sel_request` 8 → `err_underflow` 1, `enc_run` 0 the next cycle, `rd_ptr` unchanged.
6. **Reset mid-run.** `rst_n` low for one cycle mid-RUN → all outputs return to reset values after the edge.
